// File: rtl/regfile_scan_if.sv
// regfile_scan_if: register-file access and scan signals shared by a driver and the register file
interface regfile_scan_if #(
  parameter int WIDTH = 16,
  parameter int AW = 3
);
  logic test;
  logic sdi;
  logic sdo;
  logic reg_we;
  logic scan_wrap;
  logic [AW-1:0] rw;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  modport master (
    output test, sdi, reg_we, rw, wdata, rs1, rs2,
    input sdo, rd1, rd2, scan_wrap
  );
  modport slave (
    input test, sdi, reg_we, rw, wdata, rs1, rs2,
    output sdo, rd1, rd2, scan_wrap
  );
endinterface

// File: rtl/regfile_scan.sv
// regfile_scan: parametrised 2R1W register file with write bypass, optional zero R0 and a full serial scan chain
module regfile_scan #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int BYPASS = 1,
  parameter int ZERO_R0 = 0
) (
  input logic clk,
  input logic rst,
  regfile_scan_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int NA = 1 << AW;
  localparam int CHAIN = (NREGS - ZERO_R0) * WIDTH;
  localparam int IW = $clog2(CHAIN);
  localparam int CW = $clog2(CHAIN + 1);
  // All storage lives in one vector ordered {R[NREGS-1], ..., R[ZERO_R0]} so a scan shift is a plain right shift
  logic [CHAIN-1:0] chain_q, chain_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wrap_q, wrap_d;
  logic [NA-1:0] writable;
  logic [WIDTH-1:0] regs [NA];
  logic we_ok;
  // Read view of every address: real registers map into the chain, everything else reads zero
  always_comb begin
    writable = '0;
    for (int k = 0; k < NA; k++) regs[k] = '0;
    for (int k = ZERO_R0; k < NREGS; k++) begin
      writable[AW'(k)] = 1'b1;
      regs[AW'(k)] = chain_q[IW'((k - ZERO_R0) * WIDTH) +: WIDTH];
    end
  end
  // A write only counts outside scan mode and to an address that has storage; bypass follows the same rule
  always_comb begin
    we_ok = bus.reg_we && !bus.test && writable[bus.rw];
    bus.rd1 = (BYPASS != 0 && we_ok && bus.rw == bus.rs1) ? bus.wdata : regs[bus.rs1];
    bus.rd2 = (BYPASS != 0 && we_ok && bus.rw == bus.rs2) ? bus.wdata : regs[bus.rs2];
    bus.sdo = chain_q[0];
    bus.scan_wrap = wrap_q;
  end
  // Next chain contents: scan shift has priority over the write port
  always_comb begin
    chain_d = bus.test ? {bus.sdi, chain_q[CHAIN-1:1]} : chain_q;
    if (we_ok)
      for (int k = ZERO_R0; k < NREGS; k++)
        if (bus.rw == AW'(k)) chain_d[IW'((k - ZERO_R0) * WIDTH) +: WIDTH] = bus.wdata;
  end
  // Shift counter wraps after a full rotation; leaving scan mode restarts it
  always_comb begin
    wrap_d = bus.test && cnt_q == CW'(CHAIN - 1);
    cnt_d = (!bus.test || wrap_d) ? '0 : cnt_q + CW'(1);
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      cnt_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
endmodule

// File: tb/tb_regfile_scan.sv
// tb_regfile_scan: checks a default 8x16 bypassed file and a 7x16 zero-R0 unbypassed file side by side
module tb_regfile_scan;
  logic clk = 1'b0;
  logic rst;
  logic test, sdi, we;
  logic [2:0] rw, rs1, rs2;
  logic [15:0] wd;
  int errs = 0;
  int checks = 0;
  typedef struct {
    string name;
    logic [15:0] v;
  } exp_t;
  typedef struct {
    logic we;
    logic [2:0] rw;
    logic [15:0] wd;
    logic [2:0] rs1, rs2;
    logic [15:0] a1, a2, b1, b2;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[10];
  always #5 clk = ~clk;
  regfile_scan_if #(.WIDTH(16), .AW(3)) bus0 ();
  regfile_scan_if #(.WIDTH(16), .AW(3)) bus1 ();
  assign bus0.test = test;
  assign bus0.sdi = sdi;
  assign bus0.reg_we = we;
  assign bus0.rw = rw;
  assign bus0.wdata = wd;
  assign bus0.rs1 = rs1;
  assign bus0.rs2 = rs2;
  assign bus1.test = test;
  assign bus1.sdi = sdi;
  assign bus1.reg_we = we;
  assign bus1.rw = rw;
  assign bus1.wdata = wd;
  assign bus1.rs1 = rs1;
  assign bus1.rs2 = rs2;
  regfile_scan #(.WIDTH(16), .NREGS(8), .BYPASS(1), .ZERO_R0(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_scan #(.WIDTH(16), .NREGS(7), .BYPASS(0), .ZERO_R0(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  task automatic push(input string n, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_chk(input logic [15:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_empty: got %h, no expectation queued", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        errs++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; test = 0; sdi = 0; we = 0; rw = 0; wd = 0; rs1 = 3; rs2 = 7;
    tbl[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd7, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 3'd7, 16'h1234, 3'd3, 3'd7, 16'hA5A5, 16'h1234, 16'hA5A5, 16'h0000};
    tbl[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, 16'hA5A5, 16'h1234, 16'hA5A5, 16'h0000};
    tbl[3] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'hFFFF, 16'hA5A5, 16'h0000, 16'hA5A5};
    tbl[5] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd6, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
    tbl[7] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[8] = '{1'b1, 3'd4, 16'h0F0F, 3'd4, 3'd4, 16'h0F0F, 16'h0F0F, 16'h0000, 16'h0000};
    tbl[9] = '{1'b0, 3'd0, 16'h0000, 3'd4, 3'd7, 16'h0F0F, 16'h1234, 16'h0F0F, 16'h0000};
    #12 rst = 1'b0;
    @(negedge clk);
    push("reset_rd1", 0); push("reset_rd2", 0); push("reset_sdo", 0); push("reset_wrap", 0); push("reset_u1_rd1", 0);
    pop_chk(bus0.rd1); pop_chk(bus0.rd2); pop_chk({15'd0, bus0.sdo}); pop_chk({15'd0, bus0.scan_wrap}); pop_chk(bus1.rd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 we = tbl[i].we; rw = tbl[i].rw; wd = tbl[i].wd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      push($sformatf("vec%0d_u0_rd1", i), tbl[i].a1);
      push($sformatf("vec%0d_u0_rd2", i), tbl[i].a2);
      push($sformatf("vec%0d_u1_rd1", i), tbl[i].b1);
      push($sformatf("vec%0d_u1_rd2", i), tbl[i].b2);
      @(negedge clk);
      pop_chk(bus0.rd1); pop_chk(bus0.rd2); pop_chk(bus1.rd1); pop_chk(bus1.rd2);
    end
    we = 0;
    do_reset();
    we = 1; rw = 0; wd = 16'h0001;
    @(posedge clk);
    #1 test = 1; sdi = 1; we = 1; rw = 2; wd = 16'h5555; rs1 = 2; rs2 = 7;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      push($sformatf("scan_sdo_c%0d", c), (c == 0) ? 16'd1 : 16'd0);
      push($sformatf("scan_wrap_u0_c%0d", c), 0);
      push($sformatf("scan_wrap_u1_c%0d", c), (c == 96) ? 16'd1 : 16'd0);
      pop_chk({15'd0, bus0.sdo}); pop_chk({15'd0, bus0.scan_wrap}); pop_chk({15'd0, bus1.scan_wrap});
      if (c == 5) begin
        push("scan_r2_no_write", 16'h0000); push("scan_r7_partial", 16'hF800);
        pop_chk(bus0.rd1); pop_chk(bus0.rd2);
      end
      @(posedge clk);
      #1;
    end
    test = 0; we = 0;
    @(negedge clk);
    push("scan_wrap_u0_c128", 1); push("scan_wrap_u1_c128", 0); push("scan_sdo_after", 1);
    pop_chk({15'd0, bus0.scan_wrap}); pop_chk({15'd0, bus1.scan_wrap}); pop_chk({15'd0, bus0.sdo});
    for (int k = 0; k < 4; k++) begin
      rs1 = 3'(k); rs2 = 3'(k + 4);
      #1;
      push($sformatf("post_scan_u0_r%0d", k), 16'hFFFF);
      push($sformatf("post_scan_u0_r%0d", k + 4), 16'hFFFF);
      push($sformatf("post_scan_u1_r%0d", k), (k >= 1) ? 16'hFFFF : 16'h0000);
      push($sformatf("post_scan_u1_r%0d", k + 4), (k + 4 <= 6) ? 16'hFFFF : 16'h0000);
      pop_chk(bus0.rd1); pop_chk(bus0.rd2); pop_chk(bus1.rd1); pop_chk(bus1.rd2);
    end
    @(posedge clk);
    #1 test = 1; sdi = 0;
    repeat (40) @(posedge clk);
    #1 test = 0;
    @(posedge clk);
    #1 rs1 = 5; rs2 = 4;
    #1;
    push("partial_u0_r5", 16'h00FF); push("partial_u1_r4", 16'h00FF); push("partial_sdo", 1);
    pop_chk(bus0.rd1); pop_chk(bus1.rd2); pop_chk({15'd0, bus0.sdo});
    we = 1; rw = 3; wd = 16'h1111; rs1 = 1; rs2 = 2;
    #1 rst = 1;
    #1;
    push("async_rst_u0_rd1", 0); push("async_rst_u0_rd2", 0); push("async_rst_sdo", 0);
    push("async_rst_u1_rd1", 0); push("async_rst_u1_rd2", 0); push("async_rst_wrap", 0);
    pop_chk(bus0.rd1); pop_chk(bus0.rd2); pop_chk({15'd0, bus0.sdo});
    pop_chk(bus1.rd1); pop_chk(bus1.rd2); pop_chk({15'd0, bus0.scan_wrap});
    @(posedge clk);
    #2 rst = 0; we = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rs1 = 3'(k); rs2 = 3'(k + 4);
      #1;
      push($sformatf("post_rst_u0_r%0d", k), 0); push($sformatf("post_rst_u0_r%0d", k + 4), 0);
      push($sformatf("post_rst_u1_r%0d", k), 0); push($sformatf("post_rst_u1_r%0d", k + 4), 0);
      pop_chk(bus0.rd1); pop_chk(bus0.rd2); pop_chk(bus1.rd1); pop_chk(bus1.rd2);
    end
    @(posedge clk);
    #1 test = 1; sdi = 1'($urandom_range(0, 1));
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      push($sformatf("rescan_wrap_u0_c%0d", c), 0);
      push($sformatf("rescan_wrap_u1_c%0d", c), (c == 96) ? 16'd1 : 16'd0);
      pop_chk({15'd0, bus0.scan_wrap}); pop_chk({15'd0, bus1.scan_wrap});
      @(posedge clk);
      #1 sdi = 1'($urandom_range(0, 1));
    end
    test = 0;
    @(negedge clk);
    push("rescan_wrap_u0_c128", 1); push("rescan_wrap_u1_c128", 0);
    pop_chk({15'd0, bus0.scan_wrap}); pop_chk({15'd0, bus1.scan_wrap});
    @(negedge clk);
    push("wrap_one_cycle", 0);
    pop_chk({15'd0, bus0.scan_wrap});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
